mux_n_1_reg_hs: RTL and testbench

//  Parametrised, registered N:1 operand multiplexer with a valid/ready handshake on every port.

---
 rtl/mux_n_1_reg_hs.sv | 172 +++++++++++++++++
 tb/tb_mux_n_1_reg_hs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_reg_hs.sv
// mux_n_1_reg_hs: registered N:1 operand multiplexer with valid/ready on every port.
// A channel is picked by an external select (mode=0) or a round-robin arbiter
// (mode=1). The chosen word is latched into one output register, and the block
// reports the source index and a count of completed output handshakes.
module mux_n_1_reg_hs #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        xfer_cnt
);

    // N_IN widened by one bit so the range checks and the modulo wrap below
    // never overflow the index width.
    localparam logic [SEL_W:0]   N_IN_X   = (SEL_W+1)'(N_IN);
    // The pointer rests on the last channel so the first search starts at 0.
    localparam logic [SEL_W-1:0] RR_RESET = SEL_W'(N_IN-1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic             sel_ok;
    logic [N_IN-1:0]  sel_onehot;
    logic [N_IN-1:0]  rr_gnt;
    logic [N_IN-1:0]  gnt;
    logic [N_IN-1:0]  take_vec;
    logic             take;
    logic [SEL_W-1:0] take_idx;
    logic [WIDTH-1:0] take_data;

    // Round-robin candidates: candidate gi is the channel (gi+1) positions
    // after rr_ptr, wrapped modulo N_IN, held as an index and as a one-hot.
    logic [SEL_W-1:0] rr_cand_idx [N_IN];
    logic [N_IN-1:0]  rr_cand_oh  [N_IN];
    logic [N_IN-1:0]  rr_cand_vld;

    // The output register may take a new word when it is empty or being drained.
    assign load_en = !out_valid_q || out_ready;
    assign sel_ok  = ({1'b0, sel} < N_IN_X);

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
            logic [SEL_W:0] cand_sum;

            // One-hot decode of the external select; all-zero for an out-of-range sel.
            assign sel_onehot[gi] = (sel == SEL_W'(gi));

            // Pointer plus offset, brought back into range with one subtraction.
            assign cand_sum          = {1'b0, rr_ptr_q} + (SEL_W+1)'(gi + 1);
            assign rr_cand_idx[gi]   = (cand_sum >= N_IN_X) ? SEL_W'(cand_sum - N_IN_X)
                                                            : SEL_W'(cand_sum);
            for (genvar gj = 0; gj < N_IN; gj++) begin : g_oh
                assign rr_cand_oh[gi][gj] = (rr_cand_idx[gi] == SEL_W'(gj));
            end
            assign rr_cand_vld[gi] = |(rr_cand_oh[gi] & in_valid);
        end
    endgenerate

    // Round-robin grant: scan from the farthest candidate to the nearest so the
    // nearest valid channel after rr_ptr ends up as the winner.
    always_comb begin
        rr_gnt = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (rr_cand_vld[i]) begin
                rr_gnt = rr_cand_oh[i];
            end
        end
    end

    // Combined grant for either mode; at most one bit is ever set.
    always_comb begin
        gnt = '0;
        if (mode) begin
            gnt = rr_gnt;
        end else if (sel_ok) begin
            gnt = sel_onehot & in_valid;
        end
    end

    // Ready is held low in reset. In select mode it ignores in_valid, so a
    // source may wait for ready before raising valid.
    always_comb begin
        in_ready = '0;
        if (!rst) begin
            if (mode) begin
                in_ready = gnt & {N_IN{load_en}};
            end else if (sel_ok) begin
                in_ready = sel_onehot & {N_IN{load_en}};
            end
        end
    end

    assign take_vec = in_valid & in_ready;
    assign take     = |take_vec;

    // Encode the accepted channel and steer its word to the register input.
    always_comb begin
        take_idx  = '0;
        take_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (take_vec[i]) begin
                take_idx  = SEL_W'(i);
                take_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on a transfer, empty on drain without a new word,
    // otherwise hold. The counter tracks output handshakes and wraps freely.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (take) begin
            out_data_d  = take_data;
            out_src_d   = take_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = take_idx;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
        xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, (out_valid_q && out_ready)};
        sel_err_d  = !mode && !sel_ok && (|in_valid);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
            rr_ptr_q    <= RR_RESET;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_n_1_reg_hs.sv
// Directed testbench for mux_n_1_reg_hs (4 channels, 3-bit select so that
// out-of-range selects are reachable, 4-bit counter so wrap is quick).
module tb_mux_n_1_reg_hs;

    localparam int WIDTH = 32;
    localparam int N_IN  = 4;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  rst;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic [CNT_W-1:0]      xfer_cnt;

    int total;
    int bad;

    mux_n_1_reg_hs #(
        .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_channels(input logic [WIDTH-1:0] base);
        for (int i = 0; i < N_IN; i++) begin
            in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 1'b1; sel = '0; in_data = '0;
        in_valid = '1; out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 3'd0 ||
            sel_err !== 1'b0 || xfer_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d e=%b c=%0d expected all zero",
                     out_valid, out_data, out_src, sel_err, xfer_cnt);
        end
        in_valid = '0;
        #2 rst = 1'b0;
        $display("reset: outputs cleared, in_ready held low");
    endtask

    // T1: external select of channel 2.
    task automatic test_ext_select();
        tick();
        mode = 1'b0; sel = 3'd1; in_valid = '0;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin
            bad++; $display("FAIL ext_ready_no_valid: got %b expected 0010", in_ready);
        end
        sel = 3'd2;
        in_data[2*WIDTH +: WIDTH] = 32'h3F80_0000;
        in_valid = 4'b0100;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++; $display("FAIL ext_ready: got %b expected 0100", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_src !== 3'd2 || xfer_cnt !== 4'd0) begin
            bad++;
            $display("FAIL ext_load: got v=%b d=%h s=%0d c=%0d expected v=1 d=3f800000 s=2 c=0",
                     out_valid, out_data, out_src, xfer_cnt);
        end
        in_valid = '0;
        tick();
        total++;
        if (out_valid !== 1'b0 || xfer_cnt !== 4'd1 || out_data !== 32'h3F80_0000) begin
            bad++;
            $display("FAIL ext_drain: got v=%b c=%0d d=%h expected v=0 c=1 d=3f800000",
                     out_valid, xfer_cnt, out_data);
        end
        $display("ext_select: ch2 word 3f800000 loaded and drained");
    endtask

    // T2: round robin with every channel valid, one word per cycle.
    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_d;
        logic [SEL_W-1:0] exp_s;
        mode = 1'b1; out_ready = 1'b1;
        set_all_channels(32'h0000_00A0);
        in_valid = 4'b1111;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready);
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            exp_s = SEL_W'(n % 4);
            exp_d = 32'hA0 + WIDTH'(n % 4);
            total++;
            if (out_valid !== 1'b1 || out_src !== exp_s || out_data !== exp_d) begin
                bad++;
                $display("FAIL rr_seq%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         n, out_valid, out_src, out_data, exp_s, exp_d);
            end
            $display("round_robin: word %0d from ch%0d", n, out_src);
        end
        in_valid = '0;
        tick();
    endtask

    // T3: output stall for five cycles, then release.
    task automatic test_back_to_back();
        mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
        in_data[3*WIDTH +: WIDTH] = 32'h33;
        in_valid = 4'b1000;
        tick();
        out_ready = 1'b0;
        in_data[3*WIDTH +: WIDTH] = 32'h44;
        for (int n = 0; n < 5; n++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++; $display("FAIL stall_ready%0d: got %b expected 0000", n, in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h33 || out_src !== 3'd3) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b d=%h s=%0d expected v=1 d=33 s=3",
                         n, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b1000) begin
            bad++; $display("FAIL release_ready: got %b expected 1000", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h44) begin
            bad++; $display("FAIL release_load: got v=%b d=%h expected v=1 d=44", out_valid, out_data);
        end
        in_valid = '0;
        tick();
        $display("back_to_back: stall held 33, release loaded 44");
    endtask

    // T4: out-of-range select raises a one-cycle error and loads nothing.
    task automatic test_sel_err();
        mode = 1'b0; sel = 3'd5; out_ready = 1'b1;
        in_valid = 4'b0001;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            bad++; $display("FAIL selerr_ready: got %b expected 0000", in_ready);
        end
        tick();
        total++;
        if (sel_err !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h44) begin
            bad++;
            $display("FAIL selerr_pulse: got e=%b v=%b d=%h expected e=1 v=0 d=44",
                     sel_err, out_valid, out_data);
        end
        in_valid = '0;
        tick();
        total++;
        if (sel_err !== 1'b0) begin
            bad++; $display("FAIL selerr_clear: got %b expected 0", sel_err);
        end
        $display("sel_err: sel=5 flagged for one cycle");
    endtask

    // T5: 16 handshakes wrap the 4-bit counter back to 0.
    task automatic test_counter_wrap();
        rst = 1'b1;
        #2 rst = 1'b0;
        total++;
        if (xfer_cnt !== 4'd0) begin
            bad++; $display("FAIL wrap_start: got %0d expected 0", xfer_cnt);
        end
        mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
        in_valid = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            in_data[0 +: WIDTH] = WIDTH'(k);
            tick();
        end
        total++;
        if (xfer_cnt !== 4'd15 || out_data !== 32'd16) begin
            bad++; $display("FAIL wrap_15: got c=%0d d=%h expected c=15 d=10", xfer_cnt, out_data);
        end
        in_valid = '0;
        tick();
        total++;
        if (xfer_cnt !== 4'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_zero: got c=%0d v=%b expected c=0 v=0", xfer_cnt, out_valid);
        end
        $display("counter_wrap: 16 handshakes, counter %0d", xfer_cnt);
    endtask

    // T6: asynchronous reset while a word is pending.
    task automatic test_reset_mid();
        mode = 1'b1; out_ready = 1'b1;
        set_all_channels(32'h0000_00A0);
        in_valid = 4'b1111;
        tick();
        tick();
        total++;
        if (out_src !== 3'd1 || xfer_cnt !== 4'd1) begin
            bad++; $display("FAIL mid_pre: got s=%0d c=%0d expected s=1 c=1", out_src, xfer_cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || xfer_cnt !== 4'd0 || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_async: got v=%b c=%0d r=%b expected v=0 c=0 r=0000",
                     out_valid, xfer_cnt, in_ready);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_rr_ready: got %b expected 0001", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'hA0) begin
            bad++;
            $display("FAIL mid_rr_first: got v=%b s=%0d d=%h expected v=1 s=0 d=a0",
                     out_valid, out_src, out_data);
        end
        in_valid = '0;
        $display("reset_mid: pending word dropped, first grant ch%0d", out_src);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ext_select();
        test_round_robin();
        test_back_to_back();
        test_sel_err();
        test_counter_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
